sound_scheduler: RTL



---
 rtl/sound_pkg.sv | 36 +++
 rtl/priority_picker.sv | 22 ++
 rtl/sound_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound scheduler: sizing constants, FSM state type,
// per-source note tables and source index names.
// Imported by priority_picker users and by sound_scheduler.
package sound_pkg;

   localparam int NUM_REQ         = 4;  // number of sound sources, index 0 = highest priority
   localparam int NOTES_PER_SOUND = 4;  // notes in each sequence
   localparam int NOTE_FRAMES     = 6;  // frames each note is held
   localparam int GAP_FRAMES      = 2;  // silent frames after a sequence
   localparam int TONE_WIDTH      = 4;  // tone index width, 0 = silence

   localparam int SRC_W   = $clog2(NUM_REQ);
   localparam int NOTE_W  = $clog2(NOTES_PER_SOUND);
   // One frame counter serves both PLAY and GAP, so size it for the larger limit.
   localparam int FRAME_W = $clog2((NOTE_FRAMES > GAP_FRAMES) ? NOTE_FRAMES : GAP_FRAMES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [SRC_W-1:0] SND_DEATH = 2'd0;
   localparam logic [SRC_W-1:0] SND_WIN   = 2'd1;
   localparam logic [SRC_W-1:0] SND_HIT   = 2'd2;
   localparam logic [SRC_W-1:0] SND_SHOT  = 2'd3;

   // Row = source index, column = note index.
   localparam logic [TONE_WIDTH-1:0] TONE_TABLE [NUM_REQ][NOTES_PER_SOUND] = '{
      '{4'd9,  4'd7,  4'd5,  4'd3},   // player death
      '{4'd3,  4'd5,  4'd7,  4'd9},   // stage win
      '{4'd6,  4'd4,  4'd6,  4'd4},   // monster hit
      '{4'd12, 4'd11, 4'd10, 4'd0}    // player shot
   };

endpackage

// File: rtl/priority_picker.sv
// Combinational lowest-index-first selector.
// Ports: req_i request vector; vld_o any request set; idx_o index of lowest set bit (0 when none).
// Zero latency, no state; generic so other arbiters can reuse it.
module priority_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   output logic          vld_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      vld_o = |req_i;
      idx_o = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/sound_scheduler.sv
// Shares the single tone generator between game sound sources: latches request pulses,
// grants by fixed priority (index 0 first) and plays the granted note sequence paced by startOfFrame.
// Ports: clk/resetN, enableSound pause gate, startOfFrame pacing, sound_requests pulses in;
// tone_index/sound_on to sound_unit, active_source, busy (PLAY or GAP) out.
module sound_scheduler
   import sound_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  enableSound,
   input  logic                  startOfFrame,
   input  logic [NUM_REQ-1:0]    sound_requests,
   output logic [TONE_WIDTH-1:0] tone_index,
   output logic                  sound_on,
   output logic [SRC_W-1:0]      active_source,
   output logic                  busy
);

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   pending_q, pending_d;
   logic [SRC_W-1:0]     active_q, active_d;
   logic [NOTE_W-1:0]    note_q, note_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;

   logic [NUM_REQ-1:0]   req_ok;
   logic [NUM_REQ-1:0]   cand;
   logic                 gnt_vld;
   logic [SRC_W-1:0]     gnt_idx;
   logic                 grant;

   // A repeat request from the source already playing is dropped, not retriggered.
   always_comb begin
      req_ok = sound_requests;
      if (state_q == PLAY) req_ok[active_q] = 1'b0;
      cand = pending_q | req_ok;
   end

   priority_picker #(.N(NUM_REQ), .IW(SRC_W)) u_picker (
      .req_i (cand),
      .vld_o (gnt_vld),
      .idx_o (gnt_idx)
   );

   // Grants only while enabled; in PLAY only a strictly higher-priority source preempts.
   // GAP never grants, so waiting requests are served from IDLE.
   assign grant = enableSound && gnt_vld &&
                  ((state_q == IDLE) || ((state_q == PLAY) && (gnt_idx < active_q)));

   always_comb begin
      pending_d = cand;
      state_d   = state_q;
      active_d  = active_q;
      note_d    = note_q;
      frame_d   = frame_q;

      if (grant) begin
         // A startOfFrame in the grant cycle is deliberately not counted.
         pending_d[gnt_idx] = 1'b0;
         state_d            = PLAY;
         active_d           = gnt_idx;
         note_d             = '0;
         frame_d            = '0;
      end else if (enableSound && startOfFrame) begin
         case (state_q)
            PLAY: begin
               if (frame_q == FRAME_W'(NOTE_FRAMES - 1)) begin
                  frame_d = '0;
                  if (note_q == NOTE_W'(NOTES_PER_SOUND - 1)) begin
                     note_d  = '0;
                     state_d = GAP;
                  end else begin
                     note_d = note_q + 1'b1;
                  end
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
            GAP: begin
               if (frame_q == FRAME_W'(GAP_FRAMES - 1)) begin
                  frame_d = '0;
                  state_d = IDLE;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         pending_q <= '0;
         active_q  <= '0;
         note_q    <= '0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         active_q  <= active_d;
         note_q    <= note_d;
         frame_q   <= frame_d;
      end
   end

   // Outputs decode the registered state so a grant is audible one clock after the request,
   // and enableSound silences the generator without waiting for a clock.
   assign sound_on      = enableSound && (state_q == PLAY);
   assign tone_index    = sound_on ? TONE_TABLE[active_q][note_q] : '0;
   assign active_source = active_q;
   assign busy          = (state_q != IDLE);

endmodule
